// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
// Holds the load/run state encoding and the address range helper.
package cpu_mem_pkg;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

    // True when every byte-address bit above a word-addressed region of 2^aw words is zero
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return ((addr >> (aw + 32'd2)) == 32'd0);
    endfunction

endpackage

// File: rtl/cpu_mem_responder_word_ram.sv
// Single-port-write, asynchronous-read word memory; contents are never reset.
module word_ram
    import cpu_mem_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [0:(1<<AW)-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side counterpart of the cpu core: streams a program into imem while the
// core is held in reset, then serves instruction fetches and data accesses.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int IADDR_W = 6,
    parameter int DADDR_W = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load_valid,
    input  logic [WORD_W-1:0]   load_data,
    input  logic                load_last,
    output logic                load_ready,
    input  logic                load_restart,
    output logic                cpu_clrn,
    input  logic [31:0]         pc,
    output logic [WORD_W-1:0]   inst,
    input  logic [31:0]         alu_out,
    input  logic                wmem,
    input  logic [WORD_W-1:0]   data2mem,
    output logic [WORD_W-1:0]   datafmem,
    output logic [IADDR_W:0]    load_cnt,
    output logic                dmem_err
);

    localparam logic [IADDR_W-1:0] PTR_ONE  = {{(IADDR_W-1){1'b0}}, 1'b1};
    localparam logic [IADDR_W-1:0] PTR_LAST = {IADDR_W{1'b1}};
    localparam logic [IADDR_W:0]   CNT_ONE  = {{IADDR_W{1'b0}}, 1'b1};
    localparam logic [IADDR_W:0]   CNT_MAX  = {1'b1, {IADDR_W{1'b0}}};

    state_t              state_r;
    logic [IADDR_W-1:0]  wr_ptr_r;
    logic [IADDR_W:0]    load_cnt_r;
    logic                cpu_clrn_r;
    logic                load_ready_r;
    logic                dmem_err_r;

    logic                run_s;
    logic                accept_s;
    logic                last_word_s;
    logic                pc_ok_s;
    logic                d_ok_s;
    logic                dmem_we_s;
    logic                dmem_oob_s;
    logic [WORD_W-1:0]   imem_rdata_s;
    logic [WORD_W-1:0]   dmem_rdata_s;
    logic [WORD_W-1:0]   inst_s;
    logic [WORD_W-1:0]   datafmem_s;

    assign run_s       = (state_r == ST_RUN);
    assign accept_s    = load_valid & load_ready_r;
    assign last_word_s = load_last | (wr_ptr_r == PTR_LAST);
    assign pc_ok_s     = addr_in_range(pc, IADDR_W);
    assign d_ok_s      = addr_in_range(alu_out, DADDR_W);
    assign dmem_we_s   = run_s & wmem & d_ok_s;
    assign dmem_oob_s  = run_s & wmem & ~d_ok_s;

    word_ram #(.AW(IADDR_W)) u_imem (
        .clk   (clk),
        .we    (accept_s),
        .waddr (wr_ptr_r),
        .wdata (load_data),
        .raddr (pc[IADDR_W+1:2]),
        .rdata (imem_rdata_s)
    );

    word_ram #(.AW(DADDR_W)) u_dmem (
        .clk   (clk),
        .we    (dmem_we_s),
        .waddr (alu_out[DADDR_W+1:2]),
        .wdata (data2mem),
        .raddr (alu_out[DADDR_W+1:2]),
        .rdata (dmem_rdata_s)
    );

    // Fetch returns a NOP while loading or when the pc lies outside imem
    always_comb begin
        inst_s = NOP_INST;
        if (run_s && pc_ok_s) begin
            inst_s = imem_rdata_s;
        end else begin
            inst_s = NOP_INST;
        end
    end

    // Data reads of an out-of-range address return zero in either state
    always_comb begin
        datafmem_s = {WORD_W{1'b0}};
        if (d_ok_s) begin
            datafmem_s = dmem_rdata_s;
        end else begin
            datafmem_s = {WORD_W{1'b0}};
        end
    end

    // Load/run FSM with registered core reset, ready and error flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= ST_LOAD;
            wr_ptr_r     <= {IADDR_W{1'b0}};
            load_cnt_r   <= {(IADDR_W+1){1'b0}};
            cpu_clrn_r   <= 1'b0;
            load_ready_r <= 1'b1;
            dmem_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        if (load_cnt_r != CNT_MAX) begin
                            load_cnt_r <= load_cnt_r + CNT_ONE;
                        end
                        if (last_word_s) begin
                            state_r      <= ST_RUN;
                            cpu_clrn_r   <= 1'b1;
                            load_ready_r <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // Restart wins over a coincident out-of-range write
                    if (load_restart) begin
                        state_r      <= ST_LOAD;
                        wr_ptr_r     <= {IADDR_W{1'b0}};
                        load_cnt_r   <= {(IADDR_W+1){1'b0}};
                        cpu_clrn_r   <= 1'b0;
                        load_ready_r <= 1'b1;
                        dmem_err_r   <= 1'b0;
                    end else if (dmem_oob_s) begin
                        dmem_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_LOAD;
                    wr_ptr_r     <= {IADDR_W{1'b0}};
                    load_cnt_r   <= {(IADDR_W+1){1'b0}};
                    cpu_clrn_r   <= 1'b0;
                    load_ready_r <= 1'b1;
                    dmem_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign cpu_clrn   = cpu_clrn_r;
    assign load_cnt   = load_cnt_r;
    assign dmem_err   = dmem_err_r;
    assign inst       = inst_s;
    assign datafmem   = datafmem_s;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder with hand-computed expectations.
module tb_cpu_mem_responder;

    localparam int IW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          clr;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_restart;
    logic          cpu_clrn;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [31:0]   alu_out;
    logic          wmem;
    logic [31:0]   data2mem;
    logic [31:0]   datafmem;
    logic [IW:0]   load_cnt;
    logic          dmem_err;

    int n_assert = 0;
    int n_fail   = 0;

    cpu_mem_responder #(.IADDR_W(IW), .DADDR_W(DW)) dut (
        .clk          (clk),
        .clr          (clr),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_restart (load_restart),
        .cpu_clrn     (cpu_clrn),
        .pc           (pc),
        .inst         (inst),
        .alu_out      (alu_out),
        .wmem         (wmem),
        .data2mem     (data2mem),
        .datafmem     (datafmem),
        .load_cnt     (load_cnt),
        .dmem_err     (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
        load_restart = 1'b0; pc = 32'h0; alu_out = 32'h0; wmem = 1'b0; data2mem = 32'h0;
        tick; tick;
        chk("rst_clrn",  32'(cpu_clrn),   32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_cnt",   32'(load_cnt),   32'd0);
        chk("rst_err",   32'(dmem_err),   32'd0);
        chk("rst_inst",  inst,            32'h0);
        clr = 1'b0;
        tick;

        // Two-word program, second word flagged last
        load_valid = 1'b1; load_data = 32'h4021_0007; load_last = 1'b0;
        tick;
        chk("ld1_cnt",  32'(load_cnt), 32'd1);
        chk("ld1_clrn", 32'(cpu_clrn), 32'd0);
        chk("ld1_inst_forced", inst,   32'h0);
        load_data = 32'h0082_1000; load_last = 1'b1;
        tick;
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld2_cnt",   32'(load_cnt),   32'd2);
        chk("ld2_clrn",  32'(cpu_clrn),   32'd1);
        chk("ld2_ready", 32'(load_ready), 32'd0);
        pc = 32'h0;   #1 chk("inst_pc0", inst, 32'h4021_0007);
        pc = 32'h4;   #1 chk("inst_pc4", inst, 32'h0082_1000);
        pc = 32'h7;   #1 chk("inst_pc7", inst, 32'h0082_1000);
        pc = 32'h100; #1 chk("inst_oob", inst, 32'h0);
        load_valid = 1'b1; tick; load_valid = 1'b0;
        chk("run_valid_ignored", 32'(load_cnt), 32'd2);

        // Data write then read-after-write
        wmem = 1'b1; alu_out = 32'h8; data2mem = 32'h1111_1111; tick;
        alu_out = 32'h0; data2mem = 32'h2222_2222; tick;
        alu_out = 32'h8; data2mem = 32'hDEAD_BEEF; #1
        chk("wr_same_cycle_old", datafmem, 32'h1111_1111);
        tick; wmem = 1'b0; #1
        chk("wr_next_cycle_new", datafmem, 32'hDEAD_BEEF);
        alu_out = 32'hB; #1
        chk("rd_byte_bits_ignored", datafmem, 32'hDEAD_BEEF);
        chk("wr_no_err", 32'(dmem_err), 32'd0);

        // Out-of-range write
        alu_out = 32'h100; data2mem = 32'hCAFE_F00D; wmem = 1'b1; #1
        chk("oob_read_zero", datafmem, 32'h0);
        chk("oob_err_not_yet", 32'(dmem_err), 32'd0);
        tick; wmem = 1'b0;
        chk("oob_err_set", 32'(dmem_err), 32'd1);
        alu_out = 32'h0; #1
        chk("oob_no_alias_write", datafmem, 32'h2222_2222);
        tick; tick;
        chk("oob_err_sticky", 32'(dmem_err), 32'd1);

        // Restart from RUN
        load_restart = 1'b1; tick; load_restart = 1'b0;
        chk("rs_clrn",  32'(cpu_clrn),   32'd0);
        chk("rs_cnt",   32'(load_cnt),   32'd0);
        chk("rs_ready", 32'(load_ready), 32'd1);
        chk("rs_err",   32'(dmem_err),   32'd0);
        pc = 32'h0; #1 chk("rs_inst_forced", inst, 32'h0);
        wmem = 1'b1; alu_out = 32'h8; data2mem = 32'h0BAD_F00D; tick; wmem = 1'b0; #1
        chk("load_wmem_ignored", datafmem, 32'hDEAD_BEEF);
        load_restart = 1'b1; tick; load_restart = 1'b0;
        chk("load_restart_noop", 32'(load_ready), 32'd1);

        // Fill all 64 words without load_last
        load_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            load_data = 32'h1000_0000 + 32'(i);
            tick;
            if (i == 62) begin
                chk("full63_cnt",  32'(load_cnt), 32'd63);
                chk("full63_clrn", 32'(cpu_clrn), 32'd0);
            end
        end
        chk("full_cnt",   32'(load_cnt),   32'd64);
        chk("full_clrn",  32'(cpu_clrn),   32'd1);
        chk("full_ready", 32'(load_ready), 32'd0);
        load_data = 32'hFFFF_FFFF; tick; load_valid = 1'b0;
        chk("full_65th_cnt", 32'(load_cnt), 32'd64);
        pc = 32'hFC; #1 chk("full_inst_last",  inst, 32'h1000_003F);
        pc = 32'h0;  #1 chk("full_inst_first", inst, 32'h1000_0000);

        // Async clear while running with the error flag set
        wmem = 1'b1; alu_out = 32'h100; tick; wmem = 1'b0;
        chk("pre_clr_err", 32'(dmem_err), 32'd1);
        #2 clr = 1'b1; #1
        chk("clr_run_clrn",  32'(cpu_clrn),   32'd0);
        chk("clr_run_err",   32'(dmem_err),   32'd0);
        chk("clr_run_cnt",   32'(load_cnt),   32'd0);
        chk("clr_run_ready", 32'(load_ready), 32'd1);
        tick; clr = 1'b0;

        // Async clear mid-load after three words
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = 32'hA000_0000 + 32'(i);
            tick;
        end
        chk("mid_cnt3", 32'(load_cnt), 32'd3);
        load_valid = 1'b0;
        #2 clr = 1'b1; #1
        chk("mid_clr_cnt",  32'(load_cnt), 32'd0);
        chk("mid_clr_clrn", 32'(cpu_clrn), 32'd0);
        tick; clr = 1'b0;
        load_valid = 1'b1; load_data = 32'h5555_5555; load_last = 1'b1;
        tick;
        load_valid = 1'b0; load_last = 1'b0;
        chk("reload_cnt",  32'(load_cnt), 32'd1);
        chk("reload_clrn", 32'(cpu_clrn), 32'd1);
        pc = 32'h0; #1 chk("reload_inst0", inst, 32'h5555_5555);
        pc = 32'h4; #1 chk("reload_inst1_kept", inst, 32'hA000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side counterpart of the `cpu` core. It serves instruction fetches on `pc`/`inst` and data accesses on `alu_out`/`wmem`/`data2mem`/`datafmem`, and drives the core's `clrn`. A load-port FSM fills instruction memory over a valid/ready stream while the core is held in reset, then releases the core to run. It sits between the core and the top-level/testbench stimulus.

## Interface
Parameters:
- `IADDR_W`, 6: instruction memory word-address width (64 words).
- `DADDR_W`, 6: data memory word-address width (64 words).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  the load word is valid.
- `load_data`  in  32  instruction word to store.
- `load_last`  in  1  the current load word is the final one.
- `load_ready`  out  1  the block accepts a load word.
- `load_restart`  in  1  in RUN, return to LOAD.
- `cpu_clrn`  out  1  active-low reset to the core.
- `pc`  in  32  byte address for instruction fetch.
- `inst`  out  32  fetched instruction.
- `alu_out`  in  32  byte address for data access.
- `wmem`  in  1  data write enable.
- `data2mem`  in  32  write data.
- `datafmem`  out  32  read data.
- `load_cnt`  out  IADDR_W+1  number of words loaded.
- `dmem_err`  out  1  sticky flag for an out-of-range data access.

## Operation
- The FSM has two states:
  - LOAD is the reset state.
  - RUN is entered from LOAD on an accepted word with `load_last`=1, or on acceptance of word index 2^IADDR_W−1 (memory full).
  - RUN returns to LOAD when `load_restart`=1.
- Reset values:
  - state is LOAD.
  - `wr_ptr`/`load_cnt` are 0.
  - `cpu_clrn` is 0.
  - `dmem_err` is 0.
  - `load_ready` is 1.
  - Memory arrays are not cleared.
- LOAD state:
  - `load_ready`=1 and `cpu_clrn`=0.
  - Accept = `load_valid & load_ready`.
  - On accept, write `imem[wr_ptr]` ← `load_data`, then increment `wr_ptr` and `load_cnt`.
  - `wmem` is ignored.
  - `inst` is forced to 0.
- RUN state:
  - `load_ready`=0 and `cpu_clrn`=1.
  - `load_valid` is ignored.
  - `inst` = `imem[pc[IADDR_W+1:2]]`.
  - `pc[1:0]` is ignored.
  - If `pc[31:IADDR_W+2]` ≠ 0, `inst` = 0.
- Data access:
  - Index = `alu_out[DADDR_W+1:2]`.
  - An access is in range when `alu_out[31:DADDR_W+2]`=0.
  - Read: `datafmem` = `dmem[index]` if in range, else 0. This holds in both states.
  - Write: on `wmem` in RUN and in range, `dmem[index]` ← `data2mem`.
  - `wmem` in RUN while out of range: no write, and `dmem_err` ← 1.
  - `dmem_err` stays set until `clr` or `load_restart`.
- `load_restart` in RUN, on the next edge:
  - state → LOAD.
  - `wr_ptr`, `load_cnt` and `dmem_err` → 0.
  - `cpu_clrn` → 0.
- `load_restart` in LOAD has no effect.
- `load_cnt` saturates at 2^IADDR_W. It never wraps.

## Timing
- `inst` and `datafmem` are combinational from their addresses.
- The data write takes effect at the rising edge. A same-cycle read returns the old data; the new data is visible the next cycle.
- `cpu_clrn` is registered:
  - It rises on the edge that enters RUN.
  - It falls on the edge that enters LOAD.
  - It falls asynchronously on `clr`.
- Instruction fetch becomes valid in the first cycle of RUN.
- The load handshake is one word per cycle at full rate.
- A word with `load_last` counts as loaded: `load_cnt` includes it.
- `clr` asserted mid-load: the FSM returns to LOAD and the pointer goes to 0. Previously written imem words remain but will be overwritten.

## Structure
- Shared package `cpu_mem_pkg`:
  - FSM state enum `{ST_LOAD, ST_RUN}`.
  - `WORD_W`=32.
  - `NOP_INST`=32'h0.
- Sub-module `word_ram`, instantiated twice (imem and dmem):
  - Parameter `AW`.
  - Synchronous write and asynchronous read.

## Test plan
- Load sequence:
  - Stimulus: load 0x40210007 then 0x00821000 with `load_last` on the second word.
  - Required: `load_cnt`=2 and `cpu_clrn` rises on the second accept edge.
  - With `pc`=0, `inst`=0x40210007. With `pc`=4, `inst`=0x00821000.
- Data write/read:
  - Stimulus: in RUN, `wmem`=1, `alu_out`=0x8, `data2mem`=0xDEADBEEF.
  - Required: `datafmem` shows the old value in the same cycle and 0xDEADBEEF the next cycle. `dmem_err` stays 0.
- Out-of-range write:
  - Stimulus: `wmem`=1, `alu_out`=0x100 with DADDR_W=6.
  - Required: no write and `datafmem`=0. `dmem_err`=1 from the next cycle and held until `load_restart`.
- Full memory:
  - Stimulus: stream 64 words with `load_last`=0.
  - Required: RUN is entered after the 64th accept and `load_cnt`=64. A 65th `load_valid` is not accepted because `load_ready`=0.
- Restart and reset:
  - Stimulus: pulse `load_restart` in RUN.
  - Required: LOAD, `cpu_clrn`=0 and `load_cnt`=0 at the next edge. `wmem` is then ignored.
  - Stimulus: assert `clr` mid-load after 3 words.
  - Required: `cpu_clrn`=0 immediately and `load_cnt`=0.
